// File: rtl/gen_done_barrier_pkg.sv
// Shared types and helpers for the generator launch-and-join barrier.
package gen_barrier_pkg;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, COMPLETE} barrier_state_e;

  localparam int unsigned MAX_GEN = 64;

  // Counts set bits; callers zero-extend their N_GEN-wide vector to MAX_GEN.
  function automatic int unsigned popcount(input logic [MAX_GEN-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(MAX_GEN); i++) begin
      n = n + {31'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/gen_done_barrier_collector.sv
// Sticky per-generator done mask and its running popcount.
module done_collector
  import gen_barrier_pkg::*;
#(
  parameter int unsigned N_GEN = 4,
  parameter int unsigned CNT_W = $clog2(N_GEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [N_GEN-1:0] done_in,
  output logic [N_GEN-1:0] mask,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_nxt_c
);

  logic [N_GEN-1:0] new_bits;

  // Only first reports count; held or repeated bits are masked off.
  assign new_bits    = done_in & ~mask;
  assign count_nxt_c = count + CNT_W'(popcount(MAX_GEN'(new_bits)));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      mask  <= '0;
      count <= '0;
    end else if (en) begin
      mask  <= mask | new_bits;
      count <= count_nxt_c;
    end
  end

endmodule

// File: rtl/gen_done_barrier.sv
// Launch-and-join barrier: pulses start to all generators, joins their done pulses, aborts on stall.
module gen_done_barrier
  import gen_barrier_pkg::*;
#(
  parameter int unsigned N_GEN = 4,
  parameter int unsigned CNT_W = $clog2(N_GEN + 1),
  parameter int unsigned TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [TMO_W-1:0] timeout_cycles,
  output logic [N_GEN-1:0] launch,
  input  logic [N_GEN-1:0] done_in,
  output logic             busy,
  output logic [N_GEN-1:0] done_mask,
  output logic [CNT_W-1:0] done_count,
  output logic             all_done,
  output logic             timeout_err
);

  barrier_state_e   state;
  logic [TMO_W-1:0] timer;
  logic [TMO_W-1:0] limit;
  logic [CNT_W-1:0] count_nxt;
  logic             clr;
  logic             en;

  assign clr = (state == IDLE) && start;
  assign en  = (state == LAUNCH) || (state == WAIT);

  done_collector #(
    .N_GEN (N_GEN),
    .CNT_W (CNT_W)
  ) u_collector (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .en          (en),
    .done_in     (done_in),
    .mask        (done_mask),
    .count       (done_count),
    .count_nxt_c (count_nxt)
  );

  // Outputs are registered from the transition so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      limit       <= '0;
      launch      <= '0;
      busy        <= 1'b0;
      all_done    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      launch      <= '0;
      all_done    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= LAUNCH;
            launch <= '1;
            busy   <= 1'b1;
            timer  <= '0;
            limit  <= timeout_cycles;
          end
        end
        LAUNCH: state <= WAIT;
        WAIT: begin
          // Completion wins over a timeout landing on the same edge.
          if (count_nxt == CNT_W'(N_GEN)) begin
            state    <= COMPLETE;
            busy     <= 1'b0;
            all_done <= 1'b1;
          end else if ((limit != '0) && (timer == limit - TMO_W'(1))) begin
            state       <= IDLE;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else if (timer != '1) begin
            timer <= timer + TMO_W'(1);
          end
        end
        COMPLETE: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gen_done_barrier.sv
// Randomized scoreboard bench for gen_done_barrier against a set-union run model.
module tb_gen_done_barrier;

  localparam int unsigned N_GEN = 4;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned TMO_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [TMO_W-1:0] timeout_cycles;
  logic [N_GEN-1:0] launch;
  logic [N_GEN-1:0] done_in;
  logic             busy;
  logic [N_GEN-1:0] done_mask;
  logic [CNT_W-1:0] done_count;
  logic             all_done;
  logic             timeout_err;

  gen_done_barrier #(.N_GEN(N_GEN), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .timeout_cycles (timeout_cycles),
    .launch         (launch),
    .done_in        (done_in),
    .busy           (busy),
    .done_mask      (done_mask),
    .done_count     (done_count),
    .all_done       (all_done),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          timeout;
    logic [3:0]  mask;
    int unsigned cnt;
    int unsigned lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   launch_cyc = 0;
  int   launches = 0;
  int   runs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Run outcome from the rules: union of reports, first full WAIT edge completes, else limit-th WAIT edge aborts.
  function automatic exp_t model(input int unsigned lim, input logic [3:0] vq[$]);
    exp_t       e;
    logic [3:0] m;
    logic [3:0] v;
    m = vq[0];
    e.timeout = 1'b0;
    e.lat = 0;
    for (int unsigned j = 0; j < 100000; j++) begin
      v = (j + 1 < vq.size()) ? vq[j+1] : 4'h0;
      m = m | v;
      if ($countones(m) == N_GEN) begin
        e.lat = 2 + j;
        break;
      end
      if (lim != 0 && j == lim - 1) begin
        e.timeout = 1'b1;
        e.lat = 2 + j;
        break;
      end
    end
    e.mask = m;
    e.cnt = $countones(m);
    return e;
  endfunction

  // Monitor: pops an expected outcome whenever the DUT ends a run.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (launch != '0) begin
          launches++;
          launch_cyc = cyc;
          check("launch_all_ones", 64'(launch), 64'hF);
        end
        if (all_done || timeout_err) begin
          check("pulse_exclusive", 64'(all_done & timeout_err), 64'h0);
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pulse: all_done=%0b timeout_err=%0b with nothing expected", all_done, timeout_err);
          end else begin
            e = sb.pop_front();
            check("end_kind_timeout", 64'(timeout_err), 64'(e.timeout));
            check("end_kind_done", 64'(all_done), 64'(!e.timeout));
            check("end_mask", 64'(done_mask), 64'(e.mask));
            check("end_count", 64'(done_count), 64'(e.cnt));
            check("end_latency", 64'(cyc - launch_cyc), 64'(e.lat));
          end
        end
      end
    end
  end

  task automatic run(input int unsigned lim, input logic [3:0] vq[$], input bit inj);
    exp_t e;
    bit   got;
    e = model(lim, vq);
    sb.push_back(e);
    runs++;
    timeout_cycles = TMO_W'(lim);
    @(negedge clk);
    start = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (launch != '0) begin
        got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL launch_wait: no launch within 10 cycles");
      void'(sb.pop_back());
      return;
    end
    done_in = vq[0];
    for (int unsigned i = 1; i < e.lat; i++) begin
      @(negedge clk);
      done_in = (i < vq.size()) ? vq[i] : 4'h0;
      start = inj && ($urandom_range(0, 3) == 0);
    end
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      done_in = 4'($urandom);
      if (all_done || timeout_err) begin
        got = 1'b1;
        if (inj && all_done) start = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL end_wait: no all_done/timeout_err within 20 cycles");
      sb.delete();
    end
    @(negedge clk);
    start = 1'b0;
    done_in = 4'($urandom);
    @(negedge clk);
    done_in = 4'h0;
    check("hold_mask", 64'(done_mask), 64'(e.mask));
    check("hold_count", 64'(done_count), 64'(e.cnt));
    check("idle_busy", 64'(busy), 64'h0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_launch"}, 64'(launch), 64'h0);
    check({tag, "_busy"}, 64'(busy), 64'h0);
    check({tag, "_mask"}, 64'(done_mask), 64'h0);
    check({tag, "_count"}, 64'(done_count), 64'h0);
    check({tag, "_all_done"}, 64'(all_done), 64'h0);
    check({tag, "_timeout_err"}, 64'(timeout_err), 64'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  q[$];
    int unsigned lim;
    int unsigned len;
    rst = 1'b1;
    start = 1'b0;
    done_in = '0;
    timeout_cycles = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    @(negedge clk);

    q = {4'h1, 4'h2, 4'h4, 4'h8};
    run(0, q, 1'b0);
    q = {4'h0, 4'h5, 4'hA};
    run(0, q, 1'b0);
    q = {4'h0, 4'h4, 4'h5, 4'h4, 4'h5, 4'h4, 4'h5, 4'h4, 4'h5, 4'h4, 4'h4};
    run(14, q, 1'b0);
    q = {4'h0, 4'h1, 4'h2};
    run(8, q, 1'b0);
    q = {4'h0, 4'h0, 4'h0, 4'hF};
    run(3, q, 1'b0);
    q = {4'hF};
    run(0, q, 1'b1);
    q = {4'h1, 4'h2, 4'h4, 4'h8};
    run(0, q, 1'b1);

    // Reset mid-run after two reports, then a clean relaunch.
    runs++;
    timeout_cycles = '0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_in = 4'h0;
    @(negedge clk);
    done_in = 4'h1;
    @(negedge clk);
    done_in = 4'h2;
    @(negedge clk);
    done_in = 4'h0;
    check("pre_reset_count", 64'(done_count), 64'h2);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("midrun_reset");
    rst = 1'b0;
    q = {4'h1, 4'h2, 4'h4, 4'h8};
    run(0, q, 1'b0);

    for (int r = 0; r < 40; r++) begin
      lim = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 12);
      len = $urandom_range(1, 10);
      q = {};
      for (int unsigned i = 0; i < len; i++) q.push_back(4'($urandom & $urandom));
      if (lim == 0) q.push_back(4'hF);
      run(lim, q, 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    check("launch_total", 64'(launches), 64'(runs));
    check("scoreboard_drained", 64'(sb.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
